// File: rtl/framebuffer_swap_controller_if.sv
// Purpose: bundles the display read path, RAM write port, renderer handshake and swap control.
// Latency: wiring only; rd_data returns one cycle after rd_addr.
// Backpressure: renderer writes stall while px_ready is low.
// Ports: disp_* (display_driver), rd_*/wr_* (dual-port RAM), px_* (renderer),
//        swap_req/clear_on_swap/busy/front_page (page control).
// Modports: slave = controller view, master = surrounding environment view.
interface framebuffer_swap_controller_if #(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 10
);
  localparam int RB = $clog2(rows);
  localparam int CB = $clog2(columns);
  localparam int AW = 1 + RB + CB;
  localparam int PW = 3 * bitwidth;

  logic [RB-1:0] disp_row;
  logic [CB-1:0] disp_column;
  logic [PW-1:0] disp_pixel;
  logic          frame_complete;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          px_valid;
  logic          px_ready;
  logic [RB-1:0] px_row;
  logic [CB-1:0] px_column;
  logic [PW-1:0] px_data;
  logic          swap_req;
  logic          clear_on_swap;
  logic          busy;
  logic          front_page;

  modport slave (
    input  disp_row, disp_column, frame_complete, rd_data,
           px_valid, px_row, px_column, px_data, swap_req, clear_on_swap,
    output disp_pixel, rd_addr, wr_addr, wr_en, wr_data, px_ready, busy, front_page
  );

  modport master (
    output disp_row, disp_column, frame_complete, rd_data,
           px_valid, px_row, px_column, px_data, swap_req, clear_on_swap,
    input  disp_pixel, rd_addr, wr_addr, wr_en, wr_data, px_ready, busy, front_page
  );
endinterface

// File: rtl/framebuffer_swap_controller.sv
// Purpose: double-buffered framebuffer control: display reads front page, renderer writes back page.
// Latency: writes are issued the cycle they are accepted; disp_pixel follows disp_row/column by the RAM's 1 cycle.
// Backpressure: px_ready drops while a swap is pending or the clear engine is running.
// Ports: clk, rst_n (async active-low) plus the slave view of framebuffer_swap_controller_if.
module framebuffer_swap_controller #(
  parameter int                    rows        = 8,
  parameter int                    columns     = 32,
  parameter int                    bitwidth    = 10,
  parameter logic [3*bitwidth-1:0] clear_value = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  framebuffer_swap_controller_if.slave  bus
);
  localparam int RB = $clog2(rows);
  localparam int CB = $clog2(columns);
  localparam int AW = 1 + RB + CB;
  localparam int PW = 3 * bitwidth;
  localparam int NB = RB + CB;

  // rows and columns are powers of two, so the last pixel index is all ones.
  localparam logic [NB-1:0] LAST_PIX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic          front_q, front_nxt;
  logic          clr_flag_q, clr_flag_nxt;
  logic [NB-1:0] cnt_q, cnt_nxt;

  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [PW-1:0] wr_data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      clr_flag_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_nxt;
      front_q    <= front_nxt;
      clr_flag_q <= clr_flag_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    front_nxt    = front_q;
    clr_flag_nxt = clr_flag_q;
    cnt_nxt      = cnt_q;
    wr_en_c      = 1'b0;
    wr_addr_c    = {~front_q, bus.px_row, bus.px_column};
    wr_data_c    = bus.px_data;

    case (state_q)
      IDLE: begin
        // A write accepted alongside swap_req still targets the current
        // back page, since front_q only moves later in PENDING.
        wr_en_c = bus.px_valid;
        if (bus.swap_req) begin
          state_nxt    = PENDING;
          clr_flag_nxt = bus.clear_on_swap;
        end
      end
      PENDING: begin
        if (bus.frame_complete) begin
          front_nxt = ~front_q;
          cnt_nxt   = '0;
          state_nxt = clr_flag_q ? CLEAR : IDLE;
        end
      end
      CLEAR: begin
        // front_q has already flipped, so ~front_q is the page just retired.
        wr_en_c   = 1'b1;
        wr_addr_c = {~front_q, cnt_q};
        wr_data_c = clear_value;
        if (cnt_q == LAST_PIX) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // rst_n gating keeps the RAM port and the handshake quiet while reset is held.
  assign bus.wr_en      = wr_en_c & rst_n;
  assign bus.wr_addr    = wr_addr_c;
  assign bus.wr_data    = wr_data_c;
  assign bus.px_ready   = (state_q == IDLE) & rst_n;
  assign bus.busy       = (state_q != IDLE);
  assign bus.front_page = front_q;

  assign bus.rd_addr    = {front_q, bus.disp_row, bus.disp_column};
  assign bus.disp_pixel = bus.rd_data;
endmodule
